wishbone_sram_slave: RTL and testbench



---
 rtl/wishbone_sram_slave.sv | 186 ++++++++++++++++++
 tb/tb_wishbone_sram_slave.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wishbone_sram_slave.sv
`default_nettype none
// ============================================================================
//  Module      : wishbone_sram_slave
//  Description : Wishbone B4 classic single-port SRAM slave. DEPTH 32-bit
//                words mapped at BASE_ADDR, byte-lane writes, WAIT_STATES
//                wait cycles per access, one-cycle ack/err per transfer.
//  Revision    : 1.0 - initial release
// ============================================================================
module wishbone_sram_slave #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH       = 1024,
    parameter int          WAIT_STATES = 0
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        wb_rty_o
);

    localparam int          c_IDX_W = $clog2(DEPTH);
    localparam logic [32:0] c_LIMIT = {1'b0, BASE_ADDR} + 33'(4 * DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q,   cnt_d;
    logic [31:0]        adr_q,   adr_d;
    logic               we_q,    we_d;
    logic [3:0]         sel_q,   sel_d;
    logic [31:0]        wdat_q,  wdat_d;
    logic               hit_q,   hit_d;
    logic               ack_q,   ack_d;
    logic               err_q,   err_d;
    logic [31:0]        rdat_q,  rdat_d;

    logic [31:0]        mem [DEPTH];

    logic               w_req;
    logic               w_in_hit;
    logic               w_idle;
    logic [31:0]        w_eff_adr;
    logic               w_eff_we;
    logic [3:0]         w_eff_sel;
    logic [31:0]        w_eff_dat;
    logic               w_eff_hit;
    logic [31:0]        w_off;
    logic [c_IDX_W-1:0] w_idx;
    logic               w_commit;
    logic               w_wr_en;
    logic               w_unused;

    assign w_req    = wb_cyc_i & wb_stb_i;
    assign w_in_hit = ({1'b0, wb_adr_i} >= {1'b0, BASE_ADDR}) &&
                      ({1'b0, wb_adr_i} <  c_LIMIT);

    // With no wait states the response is raised at the sample edge itself,
    // so the live bus inputs are used; otherwise the latched request is used.
    assign w_idle    = (state_q == ST_IDLE);
    assign w_eff_adr = w_idle ? wb_adr_i : adr_q;
    assign w_eff_we  = w_idle ? wb_we_i  : we_q;
    assign w_eff_sel = w_idle ? wb_sel_i : sel_q;
    assign w_eff_dat = w_idle ? wb_dat_i : wdat_q;
    assign w_eff_hit = w_idle ? w_in_hit : hit_q;

    assign w_off    = w_eff_adr - BASE_ADDR;
    assign w_idx    = w_off[c_IDX_W+1:2];
    assign w_unused = ^{w_off};

    assign w_wr_en  = w_commit & w_eff_hit & w_eff_we;

    // Next-state, request latching and registered response computation
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        adr_d    = adr_q;
        we_d     = we_q;
        sel_d    = sel_q;
        wdat_d   = wdat_q;
        hit_d    = hit_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        rdat_d   = 32'h0;
        w_commit = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_req) begin
                    adr_d  = wb_adr_i;
                    we_d   = wb_we_i;
                    sel_d  = wb_sel_i;
                    wdat_d = wb_dat_i;
                    hit_d  = w_in_hit;
                    if (WAIT_STATES == 0) begin
                        state_d  = ST_RESP;
                        w_commit = 1'b1;
                    end else begin
                        cnt_d   = 4'(WAIT_STATES - 1);
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!wb_cyc_i) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d  = ST_RESP;
                    w_commit = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                // stb still high here belongs to the finished transfer
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (w_commit) begin
            ack_d = w_eff_hit;
            err_d = ~w_eff_hit;
            if (w_eff_hit && !w_eff_we) begin
                rdat_d = mem[w_idx];
            end
        end
    end

    // State, latched request and response registers
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            adr_q   <= 32'h0;
            we_q    <= 1'b0;
            sel_q   <= 4'h0;
            wdat_q  <= 32'h0;
            hit_q   <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdat_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            wdat_q  <= wdat_d;
            hit_q   <= hit_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdat_q  <= rdat_d;
        end
    end

    // Byte-lane write commit; storage itself is never reset
    always_ff @(posedge clk_i) begin
        if (w_wr_en && rstn_i) begin
            for (int b = 0; b < 4; b++) begin
                if (w_eff_sel[b]) begin
                    mem[w_idx][8*b +: 8] <= w_eff_dat[8*b +: 8];
                end
            end
        end
    end

    assign wb_dat_o = rdat_q;
    assign wb_ack_o = ack_q;
    assign wb_err_o = err_q;
    assign wb_rty_o = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_wishbone_sram_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wishbone_sram_slave
//  Description : Self-checking bench for wishbone_sram_slave. One instance
//                with no wait states and one with three share the bus
//                stimulus; use3 selects which one is active.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wishbone_sram_slave;

    typedef struct {
        bit          is_err;
        bit          is_rd;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat;
    bit          use3;

    logic        cyc0, stb0, cyc3, stb3;
    logic [31:0] dat0, dat3;
    logic        ack0, err0, rty0, ack3, err3, rty3;
    logic        ack, err;
    logic [31:0] rdat;

    exp_t        sbq[$];
    logic [31:0] model [logic [31:0]];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc_cnt  = 0;

    assign cyc0 = cyc & ~use3;
    assign stb0 = stb & ~use3;
    assign cyc3 = cyc &  use3;
    assign stb3 = stb &  use3;
    assign ack  = use3 ? ack3 : ack0;
    assign err  = use3 ? err3 : err0;
    assign rdat = use3 ? dat3 : dat0;

    wishbone_sram_slave #(.BASE_ADDR(32'h0), .DEPTH(1024), .WAIT_STATES(0)) dut0 (
        .clk_i(clk), .rstn_i(rstn), .wb_cyc_i(cyc0), .wb_stb_i(stb0),
        .wb_we_i(we), .wb_sel_i(sel), .wb_adr_i(adr), .wb_dat_i(dat),
        .wb_dat_o(dat0), .wb_ack_o(ack0), .wb_err_o(err0), .wb_rty_o(rty0)
    );

    wishbone_sram_slave #(.BASE_ADDR(32'h0), .DEPTH(1024), .WAIT_STATES(3)) dut3 (
        .clk_i(clk), .rstn_i(rstn), .wb_cyc_i(cyc3), .wb_stb_i(stb3),
        .wb_we_i(we), .wb_sel_i(sel), .wb_adr_i(adr), .wb_dat_i(dat),
        .wb_dat_o(dat3), .wb_ack_o(ack3), .wb_err_o(err3), .wb_rty_o(rty3)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] mkey(input logic [31:0] a);
        return {use3, a[30:2], 2'b00};
    endfunction

    // One Wishbone transfer; called #1 after a rising edge, returns likewise.
    task automatic xfer(input bit keep, input bit w, input logic [31:0] a,
                        input logic [3:0] s, input logic [31:0] d,
                        output int ack_at, output logic [31:0] rd);
        exp_t        e, got;
        int          ws;
        bit          hit, seen;
        int          lat;
        logic [31:0] k, old;
        ws   = use3 ? 3 : 0;
        hit  = (a < 32'h0000_1000);
        k    = mkey(a);
        old  = model.exists(k) ? model[k] : 32'hx;
        e.is_err = !hit;
        e.is_rd  = !w;
        e.data   = (hit && !w) ? old : 32'h0;
        if (hit && w) model[k] = merge(old, d, s);
        sbq.push_back(e);

        cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat = d;
        @(posedge clk);
        seen = 1'b0;
        ack_at = -1;
        rd = 32'h0;
        for (lat = 1; lat <= 20; lat++) begin
            #1;
            if (ack || err) begin seen = 1'b1; break; end
            if (ws > 0) begin dat = ~d; sel = ~s; adr = a ^ 32'h4; end
            @(posedge clk);
        end
        got = sbq.pop_front();
        n_checks++;
        if (!seen) begin
            n_errors++;
            $display("FAIL timeout adr=%h: no ack/err within 20 cycles", a);
        end else begin
            ack_at = cyc_cnt;
            rd     = rdat;
            n_checks++;
            if (lat !== ws + 1) begin
                n_errors++;
                $display("FAIL latency adr=%h: got %0d cycles, expected %0d", a, lat, ws + 1);
            end
            if ({ack, err} !== {!got.is_err, got.is_err}) begin
                n_errors++;
                $display("FAIL resp adr=%h: ack/err=%b%b, expected %b%b", a, ack, err,
                         !got.is_err, got.is_err);
            end
            if (got.is_rd || got.is_err) begin
                n_checks++;
                if (rdat !== got.data) begin
                    n_errors++;
                    $display("FAIL data adr=%h: got %h, expected %h", a, rdat, got.data);
                end
            end
        end
        @(posedge clk);
        #1;
        stb = 1'b0; cyc = keep; we = 1'b0;
        n_checks++;
        if (ack !== 1'b0 || err !== 1'b0) begin
            n_errors++;
            $display("FAIL pulse adr=%h: ack/err=%b%b one cycle later, expected 00", a, ack, err);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; dat = 0; use3 = 0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({ack0, err0, rty0, dat0, ack3, err3, rty3, dat3} !== 70'h0) begin
            n_errors++;
            $display("FAIL reset: ack0=%b err0=%b rty0=%b dat0=%h ack3=%b err3=%b rty3=%b dat3=%h, expected all 0",
                     ack0, err0, rty0, dat0, ack3, err3, rty3, dat3);
        end
        rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int t; logic [31:0] r;
        use3 = 0;
        xfer(0, 1, 32'h10, 4'hF, 32'hDEADBEEF, t, r);
        xfer(0, 0, 32'h10, 4'hF, 32'h0, t, r);
    endtask

    task automatic test_byte_lanes();
        int t; logic [31:0] r;
        use3 = 0;
        xfer(0, 1, 32'h10, 4'b0101, 32'h11223344, t, r);
        xfer(0, 0, 32'h10, 4'h0, 32'h0, t, r);
        n_checks++;
        if (r !== 32'hDE22BE44) begin
            n_errors++;
            $display("FAIL byte_lanes: got %h, expected DE22BE44", r);
        end
        xfer(0, 1, 32'h10, 4'h0, 32'hFFFFFFFF, t, r);
        xfer(0, 0, 32'h10, 4'hF, 32'h0, t, r);
    endtask

    task automatic test_wait_states();
        int t; int bad; logic [31:0] r;
        use3 = 1;
        xfer(0, 1, 32'h10, 4'hF, 32'hA5A5_0F0F, t, r);
        xfer(0, 0, 32'h10, 4'hF, 32'h0, t, r);
        // aborted write: cyc dropped two cycles into the wait period
        cyc = 1; stb = 1; we = 1; adr = 32'h10; sel = 4'hF; dat = 32'h1234_5678;
        @(posedge clk); #1;
        @(posedge clk); #1;
        cyc = 0; stb = 0; we = 0;
        bad = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (ack || err) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_errors++;
            $display("FAIL abort_no_ack: %0d cycles with ack/err, expected 0", bad);
        end
        xfer(0, 0, 32'h10, 4'hF, 32'h0, t, r);
    endtask

    task automatic test_out_of_range();
        int t; logic [31:0] r;
        use3 = 0;
        xfer(0, 1, 32'h0, 4'hF, 32'hCAFEF00D, t, r);
        xfer(0, 1, 32'h1000, 4'hF, 32'h0BAD0BAD, t, r);
        xfer(0, 0, 32'h1000, 4'hF, 32'h0, t, r);
        xfer(0, 0, 32'h0, 4'hF, 32'h0, t, r);
        xfer(0, 1, 32'hFFC, 4'hF, 32'h7777_8888, t, r);
        xfer(0, 0, 32'hFFC, 4'hF, 32'h0, t, r);
        xfer(0, 0, 32'hFFFF_FFFC, 4'hF, 32'h0, t, r);
    endtask

    task automatic test_burst(input bit w3);
        int t, prev; logic [31:0] r;
        use3 = w3;
        for (int ph = 0; ph < 2; ph++) begin
            prev = -1;
            for (int i = 0; i < 8; i++) begin
                xfer(i != 7, ph == 0, 32'h20 + 32'(4 * i), 4'hF,
                     32'h5000_0000 + 32'(i * 32'h0101_0101) + (w3 ? 32'h80 : 32'h0), t, r);
                if (prev >= 0) begin
                    n_checks++;
                    if (t - prev !== (w3 ? 5 : 2)) begin
                        n_errors++;
                        $display("FAIL burst_spacing i=%0d: got %0d, expected %0d",
                                 i, t - prev, w3 ? 5 : 2);
                    end
                end
                prev = t;
            end
        end
    endtask

    task automatic test_async_reset();
        int t; logic [31:0] r;
        // reset while ack is high, mid-cycle
        use3 = 0;
        cyc = 1; stb = 1; we = 0; adr = 32'h10; sel = 4'hF;
        @(posedge clk); #1;
        n_checks++;
        if (ack0 !== 1'b1) begin
            n_errors++;
            $display("FAIL pre_reset_ack: got %b, expected 1", ack0);
        end
        #2 rstn = 1'b0;
        #1;
        n_checks++;
        if (ack0 !== 1'b0 || dat0 !== 32'h0) begin
            n_errors++;
            $display("FAIL async_reset_resp: ack=%b dat=%h, expected 0/00000000", ack0, dat0);
        end
        cyc = 0; stb = 0;
        @(posedge clk); #1 rstn = 1'b1;
        @(posedge clk); #1;
        // reset during the wait period of a latched write
        use3 = 1;
        cyc = 1; stb = 1; we = 1; adr = 32'h10; sel = 4'hF; dat = 32'h55AA_55AA;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rstn = 1'b0;
        #1;
        n_checks++;
        if (ack3 !== 1'b0 || err3 !== 1'b0 || dat3 !== 32'h0) begin
            n_errors++;
            $display("FAIL async_reset_wait: ack=%b err=%b dat=%h, expected 0", ack3, err3, dat3);
        end
        cyc = 0; stb = 0; we = 0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk); #1;
        xfer(0, 0, 32'h10, 4'hF, 32'h0, t, r);
        xfer(0, 1, 32'h14, 4'h3, 32'h0000_9999, t, r);
        xfer(0, 0, 32'h10, 4'hF, 32'h0, t, r);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_byte_lanes();
        test_wait_states();
        test_out_of_range();
        test_burst(0);
        test_burst(1);
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
